// File: rtl/mem_stage.sv
// Memory pipeline stage: data memory with byte/half/word stores, sign/zero-extending loads and Mem->WB registers.
// Optional DM_WRITE_LOG_EN prints every committed store in simulation.
module mem_stage #(
   parameter int DM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_EX_to_Mem,
   input  logic [4:0]  RegWriteAddr_EX_to_Mem,
   input  logic [4:0]  RAddr1_EX_to_Mem,
   input  logic [59:0] InstrType_EX_to_Mem,
   input  logic [31:0] ALUOut_EX_to_Mem,
   input  logic [31:0] DMWriteData_EX_to_Mem,
   input  logic [2:0]  Tnew_WAddr_EX_to_Mem,
   input  logic [31:0] bypass_WB,
   input  logic        DMWriteDataBypassCtrl_Mem,
   output logic [31:0] PC_Mem_to_WB,
   output logic [31:0] ALUOut_Mem_to_WB,
   output logic [31:0] DMReadData_Mem_to_WB,
   output logic [4:0]  RegWriteAddr_Mem_to_WB,
   output logic [59:0] InstrType_Mem_to_WB,
   output logic [2:0]  Tnew_WAddr_Mem_to_WB,
   output logic [4:0]  RAddr1_Mem,
   output logic [4:0]  RegWriteAddr_Mem,
   output logic [2:0]  Tnew_WAddr_Mem,
   output logic [31:0] bypass_Mem
);
   localparam int AW = $clog2(DM_WORDS);

   // One-hot instruction-type bit positions
   localparam int INST_SLL = 0;
   localparam int INST_LB  = 20;
   localparam int INST_LBU = 21;
   localparam int INST_LH  = 22;
   localparam int INST_LHU = 23;
   localparam int INST_LW  = 24;
   localparam int INST_SB  = 25;
   localparam int INST_SH  = 26;
   localparam int INST_SW  = 27;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;

   logic [31:0]   mem_q [DM_WORDS];
   logic [AW-1:0] word_idx;
   logic [31:0]   rd_word;
   logic [15:0]   rd_half;
   logic [7:0]    rd_byte;
   logic [31:0]   st_data;
   logic [31:0]   wr_word_d;
   logic          is_store;

   logic [31:0] pc_q, pc_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [59:0] itype_q, itype_d;
   logic [2:0]  tnew_q, tnew_d;

   assign word_idx   = ALUOut_EX_to_Mem[AW+1:2];
   assign rd_word    = mem_q[word_idx];
   assign rd_half    = rd_word[{ALUOut_EX_to_Mem[1], 4'b0000} +: 16];
   assign rd_byte    = rd_word[{ALUOut_EX_to_Mem[1:0], 3'b000} +: 8];
   assign st_data    = DMWriteDataBypassCtrl_Mem ? bypass_WB : DMWriteData_EX_to_Mem;
   assign is_store   = InstrType_EX_to_Mem[INST_SW] | InstrType_EX_to_Mem[INST_SH]
                     | InstrType_EX_to_Mem[INST_SB];

   assign tnew_d           = (Tnew_WAddr_EX_to_Mem == 3'd0) ? 3'd0 : Tnew_WAddr_EX_to_Mem - 3'd1;
   assign Tnew_WAddr_Mem   = tnew_d;
   assign bypass_Mem       = ALUOut_EX_to_Mem;
   assign RAddr1_Mem       = RAddr1_EX_to_Mem;
   assign RegWriteAddr_Mem = RegWriteAddr_EX_to_Mem;

   // Read-modify-write merge of the addressed word
   always_comb begin
      wr_word_d = rd_word;
      if (InstrType_EX_to_Mem[INST_SW])
         wr_word_d = st_data;
      else if (InstrType_EX_to_Mem[INST_SH])
         wr_word_d[{ALUOut_EX_to_Mem[1], 4'b0000} +: 16] = st_data[15:0];
      else if (InstrType_EX_to_Mem[INST_SB])
         wr_word_d[{ALUOut_EX_to_Mem[1:0], 3'b000} +: 8] = st_data[7:0];
   end

   always_comb begin
      dm_rdata_d = 32'd0;
      if (InstrType_EX_to_Mem[INST_LW])
         dm_rdata_d = rd_word;
      else if (InstrType_EX_to_Mem[INST_LH])
         dm_rdata_d = {{16{rd_half[15]}}, rd_half};
      else if (InstrType_EX_to_Mem[INST_LHU])
         dm_rdata_d = {16'd0, rd_half};
      else if (InstrType_EX_to_Mem[INST_LB])
         dm_rdata_d = {{24{rd_byte[7]}}, rd_byte};
      else if (InstrType_EX_to_Mem[INST_LBU])
         dm_rdata_d = {24'd0, rd_byte};
   end

   always_comb begin
      pc_d    = PC_EX_to_Mem;
      alu_d   = ALUOut_EX_to_Mem;
      waddr_d = RegWriteAddr_EX_to_Mem;
      itype_d = InstrType_EX_to_Mem;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DM_WORDS; i++)
            mem_q[i] <= 32'd0;
      end else if (is_store) begin
         mem_q[word_idx] <= wr_word_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= PC_RESET;
         alu_q      <= 32'd0;
         dm_rdata_q <= 32'd0;
         waddr_q    <= 5'd0;
         itype_q    <= 60'd1 << INST_SLL;
         tnew_q     <= 3'd0;
      end else begin
         pc_q       <= pc_d;
         alu_q      <= alu_d;
         dm_rdata_q <= dm_rdata_d;
         waddr_q    <= waddr_d;
         itype_q    <= itype_d;
         tnew_q     <= tnew_d;
      end
   end

`ifdef DM_WRITE_LOG_EN
   always_ff @(posedge clk) begin
      if (reset && is_store)
         $display("@%h: *%h <= %h", PC_EX_to_Mem, {ALUOut_EX_to_Mem[31:2], 2'b00}, wr_word_d);
   end
`else
   // Store logging disabled: no extra logic
`endif

   assign PC_Mem_to_WB           = pc_q;
   assign ALUOut_Mem_to_WB       = alu_q;
   assign DMReadData_Mem_to_WB   = dm_rdata_q;
   assign RegWriteAddr_Mem_to_WB = waddr_q;
   assign InstrType_Mem_to_WB    = itype_q;
   assign Tnew_WAddr_Mem_to_WB   = tnew_q;
endmodule

// File: tb/tb_mem_stage.sv
// Random + directed bench for mem_stage against a byte-addressed memory model.
module tb_mem_stage;
   localparam int DM_WORDS = 1024;
   localparam int BYTES    = 4 * DM_WORDS;

   localparam int I_SLL = 0, I_ADDU = 1;
   localparam int I_LB = 20, I_LBU = 21, I_LH = 22, I_LHU = 23, I_LW = 24;
   localparam int I_SB = 25, I_SH = 26, I_SW = 27;

   logic        clk;
   logic        reset;
   logic [31:0] pc_in, alu_in, wdata_in, bypass_wb;
   logic [4:0]  waddr_in, raddr1_in;
   logic [59:0] itype_in;
   logic [2:0]  tnew_in;
   logic        byp_ctrl;
   logic [31:0] pc_wb, alu_wb, rdata_wb, bypass_mem;
   logic [4:0]  waddr_wb, raddr1_mem, waddr_mem;
   logic [59:0] itype_wb;
   logic [2:0]  tnew_wb, tnew_mem;

   mem_stage #(.DM_WORDS(DM_WORDS)) dut (
      .clk(clk), .reset(reset),
      .PC_EX_to_Mem(pc_in), .RegWriteAddr_EX_to_Mem(waddr_in), .RAddr1_EX_to_Mem(raddr1_in),
      .InstrType_EX_to_Mem(itype_in), .ALUOut_EX_to_Mem(alu_in),
      .DMWriteData_EX_to_Mem(wdata_in), .Tnew_WAddr_EX_to_Mem(tnew_in),
      .bypass_WB(bypass_wb), .DMWriteDataBypassCtrl_Mem(byp_ctrl),
      .PC_Mem_to_WB(pc_wb), .ALUOut_Mem_to_WB(alu_wb), .DMReadData_Mem_to_WB(rdata_wb),
      .RegWriteAddr_Mem_to_WB(waddr_wb), .InstrType_Mem_to_WB(itype_wb),
      .Tnew_WAddr_Mem_to_WB(tnew_wb), .RAddr1_Mem(raddr1_mem), .RegWriteAddr_Mem(waddr_mem),
      .Tnew_WAddr_Mem(tnew_mem), .bypass_Mem(bypass_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mb [BYTES];
   int n_tests = 0;
   int n_fail  = 0;
   int ops [10] = '{I_SLL, I_ADDU, I_LB, I_LBU, I_LH, I_LHU, I_LW, I_SB, I_SH, I_SW};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [59:0] onehot(input int op);
      logic [59:0] one;
      one = 60'd1;
      return one << op;
   endfunction

   function automatic bit is_store(input int op);
      return (op == I_SB) || (op == I_SH) || (op == I_SW);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
   endtask

   // Little-endian byte memory; addresses wrap modulo the memory size
   function automatic logic [31:0] model_load(input int op, input logic [31:0] a);
      int b, w, h;
      logic [15:0] hv;
      b = int'(a & (BYTES - 1));
      w = b & ~3;
      h = b & ~1;
      hv = {mb[h + 1], mb[h]};
      case (op)
         I_LW:  return {mb[w + 3], mb[w + 2], mb[w + 1], mb[w]};
         I_LH:  return {{16{hv[15]}}, hv};
         I_LHU: return {16'd0, hv};
         I_LB:  return {{24{mb[b][7]}}, mb[b]};
         I_LBU: return {24'd0, mb[b]};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_store(input int op, input logic [31:0] a, input logic [31:0] d);
      int b, w, h;
      b = int'(a & (BYTES - 1));
      w = b & ~3;
      h = b & ~1;
      if (op == I_SW) begin
         mb[w] = d[7:0]; mb[w + 1] = d[15:8]; mb[w + 2] = d[23:16]; mb[w + 3] = d[31:24];
      end else if (op == I_SH) begin
         mb[h] = d[7:0]; mb[h + 1] = d[15:8];
      end else if (op == I_SB) begin
         mb[b] = d[7:0];
      end
   endtask

   // Called about 1 time unit after a rising edge; returns 1 time unit after the next one
   task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] data,
                         input bit ctrl, input logic [31:0] byp, input logic [2:0] tnew);
      logic [31:0] pc, exp_rd;
      logic [4:0]  wa, ra;
      logic [2:0]  exp_tnew;
      pc = $urandom; wa = 5'($urandom); ra = 5'($urandom);
      pc_in = pc; waddr_in = wa; raddr1_in = ra; itype_in = onehot(op);
      alu_in = addr; wdata_in = data; byp_ctrl = ctrl; bypass_wb = byp; tnew_in = tnew;
      #1;
      exp_tnew = (tnew == 3'd0) ? 3'd0 : tnew - 3'd1;
      check("tnew_mem", {61'd0, tnew_mem}, {61'd0, exp_tnew});
      check("bypass_mem", {32'd0, bypass_mem}, {32'd0, addr});
      check("raddr1_mem", {59'd0, raddr1_mem}, {59'd0, ra});
      check("waddr_mem", {59'd0, waddr_mem}, {59'd0, wa});
      exp_rd = model_load(op, addr);
      @(posedge clk);
      #1;
      check("rdata_wb", {32'd0, rdata_wb}, {32'd0, exp_rd});
      check("pc_wb", {32'd0, pc_wb}, {32'd0, pc});
      check("alu_wb", {32'd0, alu_wb}, {32'd0, addr});
      check("waddr_wb", {59'd0, waddr_wb}, {59'd0, wa});
      check("itype_wb", {4'd0, itype_wb}, {4'd0, onehot(op)});
      check("tnew_wb", {61'd0, tnew_wb}, {61'd0, exp_tnew});
      if (is_store(op)) model_store(op, addr, ctrl ? byp : data);
      $display("[TB] op=%0d addr=%h data=%h ctrl=%0d rd=%h", op, addr, ctrl ? byp : data, ctrl, rdata_wb);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"}, {32'd0, pc_wb}, {32'd0, 32'h0000_3000});
      check({tag, "_itype"}, {4'd0, itype_wb}, {4'd0, onehot(I_SLL)});
      check({tag, "_tnew"}, {61'd0, tnew_wb}, 64'd0);
      check({tag, "_alu"}, {32'd0, alu_wb}, 64'd0);
      check({tag, "_rdata"}, {32'd0, rdata_wb}, 64'd0);
      check({tag, "_waddr"}, {59'd0, waddr_wb}, 64'd0);
   endtask

   task automatic random_ops(input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : 32'($urandom);
         run_op(ops[$urandom_range(0, 9)], a, $urandom, 1'($urandom_range(0, 1)), $urandom,
                3'($urandom_range(0, 7)));
      end
   endtask

   initial begin
      reset = 1'b1; pc_in = 0; waddr_in = 0; raddr1_in = 0; itype_in = onehot(I_SLL);
      alu_in = 0; wdata_in = 0; bypass_wb = 0; byp_ctrl = 0; tnew_in = 0;
      model_clear();
      #2 reset = 1'b0;
      #1 check_reset_state("rst0");
      @(posedge clk); #1;
      reset = 1'b1;

      // Word/byte/half loads after a word store
      run_op(I_SW, 32'h10, 32'h8765_4321, 1'b0, 32'h0, 3'd0);
      run_op(I_LB, 32'h13, 32'h0, 1'b0, 32'h0, 3'd2);
      check("lb_0x13", {32'd0, rdata_wb}, {32'd0, 32'hFFFF_FF87});
      run_op(I_LBU, 32'h12, 32'h0, 1'b0, 32'h0, 3'd1);
      check("lbu_0x12", {32'd0, rdata_wb}, {32'd0, 32'h0000_0065});
      run_op(I_LH, 32'h10, 32'h0, 1'b0, 32'h0, 3'd1);
      check("lh_0x10", {32'd0, rdata_wb}, {32'd0, 32'h0000_4321});

      // Partial stores merge into a zero word
      run_op(I_SH, 32'h22, 32'h1234_BEEF, 1'b0, 32'h0, 3'd0);
      run_op(I_LW, 32'h20, 32'h0, 1'b0, 32'h0, 3'd2);
      check("sh_merge", {32'd0, rdata_wb}, {32'd0, 32'hBEEF_0000});
      run_op(I_SB, 32'h21, 32'h5566_77AA, 1'b0, 32'h0, 3'd0);
      run_op(I_LW, 32'h20, 32'h0, 1'b0, 32'h0, 3'd2);
      check("sb_merge", {32'd0, rdata_wb}, {32'd0, 32'hBEEF_AA00});

      // Store data taken from the WB bypass
      run_op(I_SW, 32'h0, 32'hDEAD_DEAD, 1'b1, 32'h1234_5678, 3'd0);
      run_op(I_LW, 32'h0, 32'h0, 1'b0, 32'h0, 3'd2);
      check("bypass_store", {32'd0, rdata_wb}, {32'd0, 32'h1234_5678});

      // Address wrap and Tnew saturation
      run_op(I_SW, 32'h1000, 32'h55, 1'b0, 32'h0, 3'd0);
      check("tnew_sat", {61'd0, tnew_wb}, 64'd0);
      run_op(I_LW, 32'h0, 32'h0, 1'b0, 32'h0, 3'd2);
      check("wrap_alias", {32'd0, rdata_wb}, {32'd0, 32'h55});
      check("tnew_dec", {61'd0, tnew_wb}, 64'd1);

      random_ops(400);

      // Reset mid-run, with a store pending across the edge
      pc_in = 32'h4000; itype_in = onehot(I_SW); alu_in = 32'h40; wdata_in = 32'hCAFE_F00D;
      byp_ctrl = 1'b0;
      #2 reset = 1'b0;
      #1 check_reset_state("rst1");
      @(posedge clk); #1;
      check_reset_state("rst1_hold");
      itype_in = onehot(I_SLL);
      reset = 1'b1;
      model_clear();
      run_op(I_LW, 32'h40, 32'h0, 1'b0, 32'h0, 3'd2);
      check("pending_discard", {32'd0, rdata_wb}, 64'd0);
      for (int i = 0; i < 8; i++)
         run_op(I_LW, $urandom, 32'h0, 1'b0, 32'h0, 3'd2);

      random_ops(150);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
